// File: rtl/tow_referee.sv
// Tug-of-war match controller: moves the rope on single-player pulses, cancels simultaneous
// presses, scores round wins, holds the win display, and latches the match result.
module tow_referee #(
    parameter int FIELD_HALF  = 4,
    parameter int POS_W       = 4,
    parameter int SCORE_MAX   = 7,
    parameter int HOLD_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             l_press,
    input  logic             r_press,
    output logic [POS_W-1:0] pos,
    output logic [2:0]       l_score,
    output logic [2:0]       r_score,
    output logic [1:0]       winner,
    output logic             round_over,
    output logic             match_over
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [POS_W-1:0] CENTRE    = POS_W'(FIELD_HALF);
    localparam logic [POS_W-1:0] LEFT_ARM  = POS_W'(1);
    localparam logic [POS_W-1:0] RIGHT_ARM = POS_W'(2 * FIELD_HALF - 1);
    localparam logic [POS_W-1:0] RIGHT_END = POS_W'(2 * FIELD_HALF);
    localparam logic [2:0]       SMAX      = 3'(SCORE_MAX);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        PLAY,
        ROUND_WIN,
        MATCH_OVER
    } state_t;

    state_t           state, state_n;
    logic [POS_W-1:0] pos_n;
    logic [2:0]       l_score_n, r_score_n;
    logic [1:0]       winner_n;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_n;
    logic             l_only, r_only;

    assign l_only = l_press & ~r_press;
    assign r_only = r_press & ~l_press;

    always_comb begin
        state_n    = state;
        pos_n      = pos;
        l_score_n  = l_score;
        r_score_n  = r_score;
        winner_n   = winner;
        hold_cnt_n = hold_cnt;
        case (state)
            PLAY: begin
                // A single-player pulse one step from an end is the only way onto that end.
                if (l_only) begin
                    if (pos == LEFT_ARM && l_score < SMAX) begin
                        pos_n      = '0;
                        l_score_n  = l_score + 3'd1;
                        winner_n   = 2'b10;
                        hold_cnt_n = '0;
                        state_n    = (l_score + 3'd1 == SMAX) ? MATCH_OVER : ROUND_WIN;
                    end else if (pos > LEFT_ARM) begin
                        pos_n = pos - POS_W'(1);
                    end
                end else if (r_only) begin
                    if (pos == RIGHT_ARM && r_score < SMAX) begin
                        pos_n      = RIGHT_END;
                        r_score_n  = r_score + 3'd1;
                        winner_n   = 2'b01;
                        hold_cnt_n = '0;
                        state_n    = (r_score + 3'd1 == SMAX) ? MATCH_OVER : ROUND_WIN;
                    end else if (pos < RIGHT_ARM) begin
                        pos_n = pos + POS_W'(1);
                    end
                end
            end
            ROUND_WIN: begin
                if (hold_cnt == HOLD_LAST) begin
                    pos_n      = CENTRE;
                    winner_n   = 2'b00;
                    hold_cnt_n = '0;
                    state_n    = PLAY;
                end else begin
                    hold_cnt_n = hold_cnt + CNT_W'(1);
                end
            end
            MATCH_OVER: begin
                state_n = MATCH_OVER;
            end
            default: begin
                state_n = PLAY;
            end
        endcase
    end

    // Flags are registered from the next state so they line up with the other outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= PLAY;
            pos        <= CENTRE;
            l_score    <= '0;
            r_score    <= '0;
            winner     <= 2'b00;
            hold_cnt   <= '0;
            round_over <= 1'b0;
            match_over <= 1'b0;
        end else begin
            state      <= state_n;
            pos        <= pos_n;
            l_score    <= l_score_n;
            r_score    <= r_score_n;
            winner     <= winner_n;
            hold_cnt   <= hold_cnt_n;
            round_over <= (state_n == ROUND_WIN);
            match_over <= (state_n == MATCH_OVER);
        end
    end

endmodule

// File: tb/tb_tow_referee.sv
// Self-checking bench for tow_referee: scenario tasks plus a randomized run, all compared
// against a behavioural model of the game rules.
module tb_tow_referee;

    localparam int FH   = 4;
    localparam int SMAX = 7;
    localparam int HOLD = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       l_press = 1'b0;
    logic       r_press = 1'b0;
    logic [3:0] pos;
    logic [2:0] l_score, r_score;
    logic [1:0] winner;
    logic       round_over, match_over;

    int checks = 0;
    int passes = 0;

    // Game model: phase 0 = playing, 1 = showing a round win, 2 = match finished.
    int         m_pos, m_ls, m_rs, m_phase, m_held;
    logic [1:0] m_win;

    logic [13:0] obs, exp;

    tow_referee #(.FIELD_HALF(FH), .POS_W(4), .SCORE_MAX(SMAX), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset(reset), .l_press(l_press), .r_press(r_press),
        .pos(pos), .l_score(l_score), .r_score(r_score), .winner(winner),
        .round_over(round_over), .match_over(match_over)
    );

    always #5 clk = ~clk;

    task automatic model_update(input logic l, input logic r, input logic rst);
        if (rst) begin
            m_pos = FH; m_ls = 0; m_rs = 0; m_win = 2'b00; m_phase = 0; m_held = 0;
        end else if (m_phase == 0) begin
            if (l && !r) begin
                m_pos = m_pos - 1;
                if (m_pos == 0) begin
                    m_ls = m_ls + 1; m_win = 2'b10; m_held = 0;
                    m_phase = (m_ls == SMAX) ? 2 : 1;
                end
            end else if (r && !l) begin
                m_pos = m_pos + 1;
                if (m_pos == 2 * FH) begin
                    m_rs = m_rs + 1; m_win = 2'b01; m_held = 0;
                    m_phase = (m_rs == SMAX) ? 2 : 1;
                end
            end
        end else if (m_phase == 1) begin
            m_held = m_held + 1;
            if (m_held == HOLD) begin
                m_pos = FH; m_win = 2'b00; m_phase = 0;
            end
        end
    endtask

    function automatic logic [13:0] model_vec();
        return {4'(m_pos), 3'(m_ls), 3'(m_rs), m_win, (m_phase == 1), (m_phase == 2)};
    endfunction

    task automatic step(input logic l, input logic r, input logic rst);
        l_press = l; r_press = r; reset = rst;
        @(posedge clk);
        model_update(l, r, rst);
        #1;
        l_press = 1'b0; r_press = 1'b0; reset = 1'b0;
        obs = {pos, l_score, r_score, winner, round_over, match_over};
        exp = model_vec();
    endtask

    task automatic test_reset();
        step(0, 0, 1);
        step(1, 0, 1);
        checks++;
        if (obs !== exp || obs !== {4'd4, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0})
            $display("[TB] FAIL reset got %h expected %h", obs, exp);
        else passes++;
    endtask

    task automatic test_moves();
        step(0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0);
            checks++;
            if (obs !== exp || pos !== 4'(5 + i))
                $display("[TB] FAIL move_right got %h expected %h", obs, exp);
            else passes++;
            step(0, 0, 0);
            checks++;
            if (obs !== exp) $display("[TB] FAIL move_idle got %h expected %h", obs, exp);
            else passes++;
        end
    endtask

    task automatic test_cancel();
        step(0, 0, 1);
        step(1, 1, 0);
        checks++;
        if (obs !== exp || pos !== 4'd4) $display("[TB] FAIL cancel got %h expected %h", obs, exp);
        else passes++;
        step(1, 0, 0);
        checks++;
        if (obs !== exp || pos !== 4'd3) $display("[TB] FAIL after_cancel got %h expected %h", obs, exp);
        else passes++;
    endtask

    task automatic test_left_round();
        step(0, 0, 1);
        repeat (4) step(1, 0, 0);
        checks++;
        if (obs !== exp || obs !== {4'd0, 3'd1, 3'd0, 2'b10, 1'b1, 1'b0})
            $display("[TB] FAIL left_win got %h expected %h", obs, exp);
        else passes++;
        for (int i = 1; i <= HOLD; i++) begin
            step(0, 0, 0);
            checks++;
            if (obs !== exp || round_over !== (i < HOLD))
                $display("[TB] FAIL hold_%0d got %h expected %h", i, obs, exp);
            else passes++;
        end
        checks++;
        if (pos !== 4'd4 || winner !== 2'b00)
            $display("[TB] FAIL recentre got pos %0d winner %b expected pos 4 winner 00", pos, winner);
        else passes++;
    endtask

    task automatic test_ignore_in_roundwin();
        step(0, 0, 1);
        repeat (4) step(1, 0, 0);
        for (int i = 0; i < HOLD; i++) begin
            step(0, 1, 0);
            checks++;
            if (obs !== exp || r_score !== 3'd0)
                $display("[TB] FAIL ignore_press got %h expected %h", obs, exp);
            else passes++;
        end
        checks++;
        if (pos !== 4'd4) $display("[TB] FAIL exit_press got pos %0d expected pos 4", pos);
        else passes++;
        step(0, 1, 0);
        checks++;
        if (obs !== exp || pos !== 4'd5) $display("[TB] FAIL first_play got %h expected %h", obs, exp);
        else passes++;
    endtask

    task automatic test_match();
        step(0, 0, 1);
        for (int k = 0; k < SMAX; k++) begin
            repeat (4) step(0, 1, 0);
            checks++;
            if (obs !== exp) $display("[TB] FAIL right_round_%0d got %h expected %h", k, obs, exp);
            else passes++;
            if (k < SMAX - 1) repeat (HOLD) step(0, 0, 0);
        end
        checks++;
        if (obs !== {4'd8, 3'd0, 3'd7, 2'b01, 1'b0, 1'b1})
            $display("[TB] FAIL match_end got %h expected %h", obs, {4'd8, 3'd0, 3'd7, 2'b01, 1'b0, 1'b1});
        else passes++;
        for (int i = 0; i < 20; i++) begin
            step(1'($urandom), 1'($urandom), 0);
            checks++;
            if (obs !== exp) $display("[TB] FAIL match_frozen got %h expected %h", obs, exp);
            else passes++;
        end
        step(1, 0, 1);
        checks++;
        if (obs !== exp || obs !== {4'd4, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0})
            $display("[TB] FAIL reset_match got %h expected %h", obs, exp);
        else passes++;
    endtask

    task automatic test_reset_mid();
        step(0, 0, 1);
        repeat (4) step(0, 1, 0);
        repeat (3) step(0, 0, 0);
        step(0, 1, 1);
        checks++;
        if (obs !== exp || obs !== {4'd4, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0})
            $display("[TB] FAIL reset_mid got %h expected %h", obs, exp);
        else passes++;
        step(1, 0, 0);
        checks++;
        if (obs !== exp || pos !== 4'd3) $display("[TB] FAIL resume got %h expected %h", obs, exp);
        else passes++;
    endtask

    task automatic test_random();
        logic l, r, rst;
        step(0, 0, 1);
        for (int i = 0; i < 4000; i++) begin
            l   = ($urandom_range(99) < 40);
            r   = ($urandom_range(99) < 45);
            rst = ($urandom_range(999) < 3);
            step(l, r, rst);
            checks++;
            if (obs !== exp) $display("[TB] FAIL random_%0d got %h expected %h", i, obs, exp);
            else passes++;
            checks++;
            if (round_over && match_over) $display("[TB] FAIL flags_exclusive got 11 expected not both");
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_moves();
        test_cancel();
        test_left_round();
        test_ignore_in_roundwin();
        test_match();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/tow_referee.md
# tow_referee

Match controller for the two-player tug-of-war game. It consumes the one-cycle release pulses produced by the per-player key handlers and arbitrates simultaneous presses. It moves the rope position, detects round wins, keeps per-player scores and sequences rounds until one player wins the match. Its outputs drive the position display, the score displays and the win indicators.

## Interface
- FIELD_HALF, 4: positions either side of centre; rope index spans 0..2*FIELD_HALF, centre = FIELD_HALF.
- POS_W, 4: width of pos; must hold 2*FIELD_HALF.
- SCORE_MAX, 7: round wins needed to take the match; score width 3 bits (SCORE_MAX ≤ 7).
- HOLD_CYCLES, 8: cycles the round-win display is held before re-centring (≥ 1).

- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high; clock clk
- l_press  in  1  left-player pulse, one cycle per key action, already synchronised
- r_press  in  1  right-player pulse, same form
- pos  out  POS_W  rope index; 0 = left end, 2*FIELD_HALF = right end
- l_score  out  3  left rounds won
- r_score  out  3  right rounds won
- winner  out  2  2'b10 = left won the current round/match, 2'b01 = right, 2'b00 = none
- round_over  out  1  high while in ROUND_WIN
- match_over  out  1  high while in MATCH_OVER

## Operation
- States: PLAY, ROUND_WIN, MATCH_OVER. All outputs are registered.
- Reset values: state PLAY, pos = FIELD_HALF, l_score = r_score = 0, winner = 00, round_over = 0, match_over = 0, hold counter 0.
- PLAY, l_press only: pos decrements by 1.
- PLAY, r_press only: pos increments by 1.
- PLAY, both pulses in the same cycle: cancel; pos unchanged, no score change.
- PLAY, neither pulse: hold.
- Left round win, when l_press is alone and pos == 1:
  - same edge: pos becomes 0, l_score increments, winner becomes 10.
  - state goes to MATCH_OVER if the new l_score == SCORE_MAX, else to ROUND_WIN.
- Right round win is symmetric: pos == 2*FIELD_HALF-1 with r_press alone; pos becomes 2*FIELD_HALF, r_score increments, winner becomes 01.
- ROUND_WIN:
  - Presses are ignored.
  - The hold counter counts from 0. On the edge where it reaches HOLD_CYCLES-1: pos returns to FIELD_HALF, winner clears to 00, the counter clears, state returns to PLAY.
- MATCH_OVER:
  - pos, scores and winner are frozen; presses are ignored.
  - Only reset leaves this state.
- Scores never wrap. The increment is reachable only while score < SCORE_MAX.
- pos never leaves 0..2*FIELD_HALF. End positions are reachable only through the win transition.

## Timing
- Pulse sampled at edge N; pos/score/winner/state updated at edge N (visible from cycle N+1). Latency is 1 cycle.
- round_over is high for exactly HOLD_CYCLES cycles after the winning edge. The first cycle after that is PLAY with pos at centre, and a press in that cycle is accepted.
- A press arriving in the same cycle ROUND_WIN exits is ignored, because the state is still ROUND_WIN when it is sampled.
- Reset dominates every state and any press in the same cycle. Outputs take their reset values at that edge, including mid-hold and in MATCH_OVER.
- match_over and round_over are never both high.

## Test plan
- Reset, then r_press pulses on 3 separated cycles -> pos 4→5→6→7, each change one cycle after its pulse; scores 0, winner 00.
- From pos = 4, l_press and r_press in the same cycle, then l_press alone -> pos stays 4 on the first edge, then becomes 3.
- l_press ×4 from centre -> on the 4th pulse pos = 0, l_score = 1, winner = 10, round_over = 1 for 8 cycles; then pos = 4, winner = 00, round_over = 0.
- During ROUND_WIN, pulse r_press every cycle, including the exit cycle -> pos stays 0, r_score stays 0; first move occurs only on a press in PLAY.
- Right player wins 7 rounds -> after the 7th win r_score = 7, winner = 01, match_over = 1, round_over = 0, pos = 8. Further presses for 20 cycles change nothing.
- reset asserted mid-ROUND_WIN (hold count 3), and separately in MATCH_OVER -> at the next edge pos = 4, scores 0, winner 00, flags low; play resumes normally.
